// File: rtl/cpu_pkg.sv
// Shared core definitions: sequencer states, special opcodes, opcode class helpers.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_IMM  = 2'd1,
    S_HALT = 2'd2
  } seq_state_t;

  localparam logic [6:0] OPC_HLT  = 7'b1100001;
  localparam logic [6:0] OPC_IADD = 7'b0100000;

  // IMM-class instructions carry a trailing immediate word; identified by the top two opcode bits.
  function automatic logic is_imm_class(input logic [1:0] opc_top);
    return (opc_top == 2'b01);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the decode operands and a load in EX.
module hazard_detect #(
  parameter int REG_W = 3
) (
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rdst,
  output logic             hazard
);

  // A load in EX whose destination feeds a live decode operand cannot be forwarded in time.
  always_comb begin
    hazard = id_valid & ex_mem_read &
             ((id_use_src1 & (id_src1 == ex_rdst)) |
              (id_use_src2 & (id_src2 == ex_rdst)));
  end

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencing controller: PC / IF-ID / ID-EX enables, immediate fetch, halt, stall counter.
module pipe_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int OPC_W = 7,
  parameter int REG_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [OPC_W-1:0] id_opcode,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rdst,
  input  logic             ex_branch_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             imm_capture,
  output logic             imm_sel,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             hazard;
  logic             dec_hlt;
  logic             dec_imm;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .id_valid    (id_valid),
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_use_src1 (id_use_src1),
    .id_use_src2 (id_use_src2),
    .ex_mem_read (ex_mem_read),
    .ex_rdst     (ex_rdst),
    .hazard      (hazard)
  );

  assign dec_hlt   = id_valid & (id_opcode == OPC_W'(OPC_HLT));
  assign dec_imm   = id_valid & is_imm_class(id_opcode[OPC_W-1 -: 2]);
  assign stall_cnt = stall_cnt_q;

  // Next-state, stall counter update and pipeline control outputs.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    imm_capture = 1'b0;
    imm_sel     = 1'b0;
    halted      = 1'b0;
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;

    if (reset) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = S_RUN;
      stall_cnt_d = '0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (ex_branch_taken) begin
            pc_en       = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (hazard) begin
            // One bubble is enough: the load leaves EX and its result becomes forwardable.
            idex_bubble = 1'b1;
            if (stall_cnt_q != '1) begin
              stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
          end else if (dec_hlt) begin
            // HLT itself issues so it reaches retirement; fetch freezes from here on.
            state_d = S_HALT;
          end else if (dec_imm) begin
            // Hold the IMM-class instruction in decode while the PC steps past its immediate word.
            pc_en       = 1'b1;
            idex_bubble = 1'b1;
            imm_capture = 1'b1;
            state_d     = S_IMM;
          end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
          end
        end
        S_IMM: begin
          state_d = S_RUN;
          if (ex_branch_taken) begin
            pc_en       = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
            imm_sel = 1'b1;
          end
        end
        S_HALT: begin
          idex_bubble = 1'b1;
          halted      = 1'b1;
        end
        default: begin
          // Unused encoding: keep the pipeline quiet and fall back to normal run.
          idex_bubble = 1'b1;
          state_d     = S_RUN;
        end
      endcase
    end
  end

  // State and stall counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Directed vector bench for pipe_seq_ctrl, plus a narrow-counter saturation sequence.
module tb_pipe_seq_ctrl;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [6:0] id_opcode;
  logic [2:0] id_src1, id_src2;
  logic       id_use_src1, id_use_src2;
  logic       ex_mem_read;
  logic [2:0] ex_rdst;
  logic       ex_branch_taken;
  logic       pc_en, ifid_en, ifid_flush, idex_bubble, imm_capture, imm_sel, halted;
  logic [15:0] stall_cnt;

  // Second instance with a 4-bit counter for saturation.
  logic       r2, mr2;
  logic       pc_en2, ifid_en2, ifid_flush2, idex_bubble2, imm_capture2, imm_sel2, halted2;
  logic [3:0] stall_cnt2;

  int checks = 0;
  int errors = 0;

  pipe_seq_ctrl #(.OPC_W(7), .REG_W(3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_src1(id_src1), .id_src2(id_src2), .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
    .ex_mem_read(ex_mem_read), .ex_rdst(ex_rdst), .ex_branch_taken(ex_branch_taken),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .imm_capture(imm_capture), .imm_sel(imm_sel), .halted(halted), .stall_cnt(stall_cnt)
  );

  pipe_seq_ctrl #(.OPC_W(7), .REG_W(3), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(r2), .id_valid(1'b1), .id_opcode(7'b0000001),
    .id_src1(3'd5), .id_src2(3'd0), .id_use_src1(1'b1), .id_use_src2(1'b0),
    .ex_mem_read(mr2), .ex_rdst(3'd5), .ex_branch_taken(1'b0),
    .pc_en(pc_en2), .ifid_en(ifid_en2), .ifid_flush(ifid_flush2), .idex_bubble(idex_bubble2),
    .imm_capture(imm_capture2), .imm_sel(imm_sel2), .halted(halted2), .stall_cnt(stall_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output word: {pc_en, ifid_en, ifid_flush, idex_bubble, imm_capture, imm_sel, halted}
  localparam logic [6:0] O_RST   = 7'b0011000;
  localparam logic [6:0] O_RUN   = 7'b1100000;
  localparam logic [6:0] O_BR    = 7'b1011000;
  localparam logic [6:0] O_STALL = 7'b0001000;
  localparam logic [6:0] O_IMM0  = 7'b1001100;
  localparam logic [6:0] O_IMM1  = 7'b1100010;
  localparam logic [6:0] O_HLTI  = 7'b0000000;
  localparam logic [6:0] O_HALT  = 7'b0001001;

  localparam logic [6:0] ADD  = 7'b0000001;
  localparam logic [6:0] IADD = 7'b0100000;
  localparam logic [6:0] IMMX = 7'b0111111;
  localparam logic [6:0] HLT  = 7'b1100001;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [6:0]  opc;
    logic [2:0]  s1;
    logic [2:0]  s2;
    logic        u1;
    logic        u2;
    logic        mr;
    logic [2:0]  rd;
    logic        br;
    logic [6:0]  exp;
    logic [15:0] cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic vld, input logic [6:0] opc,
                     input logic [2:0] s1, input logic [2:0] s2, input logic u1, input logic u2,
                     input logic mr, input logic [2:0] rd, input logic br,
                     input logic [6:0] exp, input logic [15:0] cnt);
    vec_t v;
    v.rst = rst; v.vld = vld; v.opc = opc; v.s1 = s1; v.s2 = s2; v.u1 = u1; v.u2 = u2;
    v.mr = mr; v.rd = rd; v.br = br; v.exp = exp; v.cnt = cnt;
    vq.push_back(v);
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  logic [6:0] got;

  initial begin
    reset = 1'b1; id_valid = 1'b1; id_opcode = ADD; id_src1 = 3'd1; id_src2 = 3'd2;
    id_use_src1 = 1'b0; id_use_src2 = 1'b0; ex_mem_read = 1'b0; ex_rdst = 3'd0;
    ex_branch_taken = 1'b0; r2 = 1'b1; mr2 = 1'b0;

    //   rst vld opc   s1 s2 u1 u2 mr rd br  expected  cnt
    add(1, 1, ADD,  1, 2, 0, 0, 0, 0, 0, O_RST,   0);  // 0 reset
    add(1, 1, ADD,  1, 2, 0, 0, 0, 0, 0, O_RST,   0);  // 1 reset
    add(0, 1, ADD,  1, 2, 0, 0, 0, 0, 0, O_RUN,   0);  // 2 first run cycle
    add(0, 1, IADD, 1, 2, 0, 0, 0, 0, 0, O_IMM0,  0);  // 3 IADD capture
    add(0, 1, IADD, 1, 2, 0, 0, 0, 0, 0, O_IMM1,  0);  // 4 IADD issue with imm
    add(0, 1, ADD,  1, 2, 0, 0, 0, 0, 0, O_RUN,   0);  // 5 normal
    add(0, 1, ADD,  1, 3, 0, 1, 1, 3, 0, O_STALL, 0);  // 6 load-use on src2
    add(0, 1, ADD,  1, 3, 0, 0, 1, 3, 0, O_RUN,   1);  // 7 src2 unused: no stall
    add(0, 1, ADD,  3, 2, 1, 0, 1, 3, 0, O_STALL, 1);  // 8 load-use on src1
    add(0, 0, ADD,  3, 2, 1, 0, 1, 3, 0, O_RUN,   2);  // 9 invalid decode: no stall
    add(0, 1, ADD,  3, 2, 1, 0, 1, 3, 1, O_BR,    2);  // 10 branch beats hazard
    add(0, 1, ADD,  1, 2, 0, 0, 0, 0, 0, O_RUN,   2);  // 11 counter untouched
    add(0, 1, IADD, 1, 2, 0, 0, 0, 0, 0, O_IMM0,  2);  // 12 IADD capture
    add(0, 1, IADD, 1, 2, 0, 0, 0, 0, 1, O_BR,    2);  // 13 branch in S_IMM
    add(0, 1, IMMX, 1, 2, 0, 0, 0, 0, 0, O_IMM0,  2);  // 14 other IMM-class op
    add(0, 1, IMMX, 4, 2, 1, 0, 1, 4, 0, O_IMM1,  2);  // 15 hazard ignored in S_IMM
    add(0, 1, HLT,  1, 2, 0, 0, 0, 0, 0, O_HLTI,  2);  // 16 HLT issues
    for (int i = 0; i < 10; i++)                        // 17..26 halted, branch/hazard ignored
      add(0, 1, ADD, 3, 2, 1, 0, i[1], 3, i[0], O_HALT, 2);
    add(1, 1, ADD,  1, 2, 0, 0, 0, 0, 0, O_RST,   2);  // 27 reset out of HALT
    add(0, 1, ADD,  1, 2, 0, 0, 0, 0, 0, O_RUN,   0);  // 28 back in S_RUN
    add(0, 1, IADD, 1, 2, 0, 0, 0, 0, 0, O_IMM0,  0);  // 29 IADD capture
    add(1, 1, ADD,  1, 2, 0, 0, 0, 0, 0, O_RST,   0);  // 30 reset mid-IMM
    add(0, 1, ADD,  1, 2, 0, 0, 0, 0, 0, O_RUN,   0);  // 31 no imm_sel leftover
    add(0, 0, HLT,  1, 2, 0, 0, 0, 0, 0, O_RUN,   0);  // 32 invalid HLT ignored
    add(0, 1, IADD, 1, 2, 0, 0, 0, 0, 1, O_BR,    0);  // 33 branch beats IADD
    add(0, 1, ADD,  1, 2, 0, 0, 0, 0, 0, O_RUN,   0);  // 34 no S_IMM entered

    @(posedge clk); #1;
    for (int k = 0; k < vq.size(); k++) begin
      reset = vq[k].rst; id_valid = vq[k].vld; id_opcode = vq[k].opc;
      id_src1 = vq[k].s1; id_src2 = vq[k].s2; id_use_src1 = vq[k].u1; id_use_src2 = vq[k].u2;
      ex_mem_read = vq[k].mr; ex_rdst = vq[k].rd; ex_branch_taken = vq[k].br;
      @(negedge clk);
      got = {pc_en, ifid_en, ifid_flush, idex_bubble, imm_capture, imm_sel, halted};
      checks++;
      if (got !== vq[k].exp) begin
        errors++;
        $display("FAIL vec%0d_ctrl actual=%b required=%b", k, got, vq[k].exp);
      end
      check16($sformatf("vec%0d_stall_cnt", k), stall_cnt, vq[k].cnt);
      if ((ifid_en & ifid_flush) !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d_en_flush actual=1 required=0", k);
      end
      checks++;
      $display("vec %0d rst=%b opc=%b br=%b ctrl=%b cnt=%0d", k, vq[k].rst, vq[k].opc, vq[k].br, got, stall_cnt);
      @(posedge clk); #1;
    end

    // Saturation on the 4-bit counter: hold a hazard for 20 cycles.
    r2 = 1'b0; mr2 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (c == 13) check16("sat_cnt_at14", {12'd0, stall_cnt2}, 16'd14);
    end
    @(negedge clk);
    check16("sat_cnt_final", {12'd0, stall_cnt2}, 16'd15);
    check16("sat_stall_ctrl", {9'd0, pc_en2, ifid_en2, ifid_flush2, idex_bubble2, imm_capture2, imm_sel2, halted2}, {9'd0, O_STALL});
    $display("sat cnt=%0d after 20 hazard cycles", stall_cnt2);
    mr2 = 1'b0;
    @(posedge clk); #1;
    check16("sat_release_ctrl", {9'd0, pc_en2, ifid_en2, ifid_flush2, idex_bubble2, imm_capture2, imm_sel2, halted2}, {9'd0, O_RUN});
    check16("sat_hold_cnt", {12'd0, stall_cnt2}, 16'd15);
    r2 = 1'b1;
    @(posedge clk); #1;
    check16("sat_reset_cnt", {12'd0, stall_cnt2}, 16'd0);
    $display("sat reset cnt=%0d", stall_cnt2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
